alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external combinational ALU: accepts one opcode and operand pair,
// presents them to the ALU for one cycle, then captures and holds the result with flags until it is consumed.
module alu_sequencer #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [N-1:0] src_a,
    input  logic [N-1:0] src_b,
    output logic [3:0]   selector,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    input  logic [N-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         neg,
    output logic         illegal,
    output logic [15:0]  op_count
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [3:0]  OP_LAST = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               in_ready_next;
    logic               res_valid_next;
    logic [3:0]         selector_next;
    logic [N-1:0]       op_a_next;
    logic [N-1:0]       op_b_next;
    logic [N-1:0]       result_next;
    logic               zero_next;
    logic               neg_next;
    logic               illegal_next;
    logic [CNT_W-1:0]   count_next;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            selector  <= 4'b0000;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            illegal   <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_next;
            res_valid <= res_valid_next;
            selector  <= selector_next;
            op_a      <= op_a_next;
            op_b      <= op_b_next;
            result    <= result_next;
            zero      <= zero_next;
            neg       <= neg_next;
            illegal   <= illegal_next;
            op_count  <= count_next;
        end
    end

    // Next-state and next-output logic; handshake and status flops track the next state
    always_comb begin
        state_next    = state;
        selector_next = selector;
        op_a_next     = op_a;
        op_b_next     = op_b;
        result_next   = result;
        zero_next     = zero;
        neg_next      = neg;
        illegal_next  = illegal;
        count_next    = op_count;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (opcode <= OP_LAST) begin
                        selector_next = opcode;
                        op_a_next     = src_a;
                        op_b_next     = src_b;
                        state_next    = EXEC;
                    end else begin
                        // Illegal opcode skips the ALU entirely; operand registers keep old values
                        result_next  = '0;
                        zero_next    = 1'b1;
                        neg_next     = 1'b0;
                        illegal_next = 1'b1;
                        state_next   = DONE;
                    end
                end
            end
            EXEC: begin
                result_next  = alu_out;
                zero_next    = (alu_out == '0);
                neg_next     = alu_out[N-1];
                illegal_next = 1'b0;
                state_next   = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    count_next = op_count + CNT_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        in_ready_next  = (state_next == IDLE);
        res_valid_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer (N=8) with a transaction-level reference model
// and a behavioural ALU attached to the selector/operand outputs.
module tb_alu_sequencer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = 4'd0;
    logic [N-1:0] src_a = '0;
    logic [N-1:0] src_b = '0;
    logic [3:0]   selector;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] alu_out;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] result;
    logic         zero;
    logic         neg;
    logic         illegal;
    logic [15:0]  op_count;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [15:0]  exp_count = '0;
    logic [3:0]   exp_sel = '0;
    logic [N-1:0] exp_a = '0;
    logic [N-1:0] exp_b = '0;

    alu_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .src_a(src_a), .src_b(src_b), .selector(selector),
        .op_a(op_a), .op_b(op_b), .alu_out(alu_out), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .zero(zero), .neg(neg),
        .illegal(illegal), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU seen by the sequencer; shift amount is op_b[2:0]
    always_comb begin
        case (selector)
            4'd0:    alu_out = op_a + op_b;
            4'd1:    alu_out = op_a - op_b;
            4'd2:    alu_out = op_a & op_b;
            4'd3:    alu_out = op_a | op_b;
            4'd4:    alu_out = op_a ^ op_b;
            4'd5:    alu_out = ~op_a;
            4'd6:    alu_out = op_a <<< op_b[2:0];
            4'd7:    alu_out = N'($signed(op_a) >>> op_b[2:0]);
            4'd8:    alu_out = op_a << op_b[2:0];
            4'd9:    alu_out = op_a >> op_b[2:0];
            4'd10:   alu_out = op_a;
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected ALU value from plain integer arithmetic
    function automatic int model(input int op, input int a, input int b);
        int amt = b % 8;
        int sa  = (a >= 128) ? a - 256 : a;
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return 255 - a;
            6, 8:    return (a * (1 << amt)) % 256;
            7:       return (sa >>> amt) & 255;
            9:       return a / (1 << amt);
            10:      return a;
            default: return 0;
        endcase
    endfunction

    task automatic noise(input bit on);
        if (on) begin
            in_valid = 1'b1;
            opcode   = 4'($urandom);
            src_a    = N'($urandom);
            src_b    = N'($urandom);
        end
    endtask

    // One full transaction; caller is positioned just after a clock edge or on a falling edge
    task automatic run_op(input logic [3:0] opc, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int stall, input bit noisy);
        bit legal = (opc <= 4'd10);
        int er, lat, w;
        bit ez, en, ei;
        if (legal) begin
            er = model(int'(opc), int'(a), int'(b));
            ez = (er == 0); en = (er >= 128); ei = 1'b0;
            exp_sel = opc; exp_a = a; exp_b = b;
        end else begin
            er = 0; ez = 1'b1; en = 1'b0; ei = 1'b1;
        end
        w = 0;
        while (!in_ready && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; opcode = opc; src_a = a; src_b = b; res_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        noise(noisy);
        lat = 1;
        while (!res_valid && lat < 5) begin
            if (lat == 1) begin
                check("exec_selector", 32'(selector), 32'(exp_sel));
                check("exec_op_a", 32'(op_a), 32'(exp_a));
                check("exec_in_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            noise(noisy);
            lat++;
        end
        check("latency", 32'(lat), legal ? 32'd2 : 32'd1);
        check("selector", 32'(selector), 32'(exp_sel));
        check("op_ab", {16'd0, op_a, op_b}, {16'd0, exp_a, exp_b});
        check("result", 32'(result), 32'(er));
        check("flags_zni", {29'd0, zero, neg, illegal}, {29'd0, ez, en, ei});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            noise(noisy);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_result", {23'd0, result, zero}, {23'd0, 8'(er), ez});
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_count", 32'(op_count), 32'(exp_count));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        exp_count = exp_count + 16'd1;
        check("retire_count", 32'(op_count), 32'(exp_count));
        check("retire_valid", 32'(res_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {selector, op_a, op_b, result, res_valid, zero, neg, illegal},
              36'd0);
        check({tag, "_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed: add, sub to zero, sub negative, illegal, recovery, backpressure with noise
        run_op(4'b0000, 8'h05, 8'h03, 0, 1'b0);
        run_op(4'b0001, 8'h07, 8'h07, 1, 1'b0);
        run_op(4'b0001, 8'h01, 8'h02, 0, 1'b0);
        run_op(4'b1100, 8'h11, 8'h22, 2, 1'b1);
        run_op(4'b0010, 8'hF0, 8'h3C, 0, 1'b0);
        run_op(4'b0111, 8'h90, 8'h03, 5, 1'b1);
        run_op(4'b1111, 8'h00, 8'h00, 0, 1'b0);
        run_op(4'b1010, 8'h00, 8'h55, 0, 1'b0);

        for (int k = 0; k < 60; k++)
            run_op(4'($urandom_range(0, 15)), N'($urandom), N'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));

        // Abort during EXEC: asynchronous clear, nothing retired
        in_valid = 1'b1; opcode = 4'b0000; src_a = 8'h21; src_b = 8'h12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_in_exec", 32'(res_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("abort");
        exp_count = '0; exp_sel = '0; exp_a = '0; exp_b = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b1100, 8'h00, 8'h00, 0, 1'b0);
        run_op(4'b0100, 8'hAA, 8'h0F, 1, 1'b0);

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.op_count = 16'hFFFE;
        #1 release dut.op_count;
        exp_count = 16'hFFFE;
        run_op(4'b0011, 8'h01, 8'h02, 0, 1'b0);
        run_op(4'b0000, 8'h80, 8'h80, 0, 1'b0);
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
